led_scanner: RTL and testbench

- Parametrised LED sweep engine ("Knight Rider" successor). A prescaler tick advances a position register across N_LEDS outputs.
- Four run-time modes: bounce, wrap-up, wrap-down, bar-fill.
- Sits between board clock/switches and the LED pins. Exposes position, direction and an end-of-sweep pulse for other blocks.

---
 rtl/led_scanner_pkg.sv | 29 ++
 rtl/led_scanner_tick.sv | 39 +++
 rtl/led_scanner.sv | 132 +++++++++++++
 tb/tb_led_scanner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scanner_pkg.sv
// Shared types and helpers for the LED sweep engine: run modes, sweep direction and the fill-bar mask.
package led_scanner_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'b00,
        MODE_WRAP_UP = 2'b01,
        MODE_WRAP_DN = 2'b10,
        MODE_FILL    = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    localparam int unsigned MAX_LEDS = 64;

    // Bits [pos:0] set, limited to the lowest n bits.
    function automatic logic [MAX_LEDS-1:0] fill_mask(input int unsigned pos, input int unsigned n);
        logic [MAX_LEDS-1:0] ones;
        logic [MAX_LEDS-1:0] bar;
        logic [MAX_LEDS-1:0] lim;
        ones = '1;
        bar  = (pos >= MAX_LEDS) ? ones : ~(ones << (pos + 1));
        lim  = (n >= MAX_LEDS) ? ones : ~(ones << n);
        return bar & lim;
    endfunction

endpackage

// File: rtl/led_scanner_tick.sv
// Free-running prescaler: TICK strobes once every PRESCALE enabled cycles; CLEAR restarts the count.
module tick_gen #(
    parameter int unsigned PRESCALE = 1250000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic ENABLE,
    input  logic CLEAR,
    output logic TICK
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (CLEAR) begin
            cnt_d = '0;
        end else if (ENABLE) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = ENABLE && !CLEAR && at_last;

endmodule

// File: rtl/led_scanner.sv
// LED sweep engine (bounce / wrap-up / wrap-down / bar-fill) stepped by tick_gen.
// Optional LED_SCANNER_TRAIL_EN: one-hot modes also light the previous position.
//   state  | meaning
//   DIR_UP | stepping toward MSB
//   DIR_DN | stepping toward LSB
import led_scanner_pkg::*;

module led_scanner #(
    parameter  int unsigned N_LEDS   = 8,
    parameter  int unsigned PRESCALE = 1250000,
    localparam int unsigned POS_W    = $clog2(N_LEDS)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ENABLE,
    input  logic              CLEAR,
    input  logic [1:0]        MODE,
    output logic [N_LEDS-1:0] LEDS,
    output logic [POS_W-1:0]  POS,
    output logic              DIR,
    output logic              TICK,
    output logic              SWEEP
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic              tick;
    logic [POS_W-1:0]  pos_q, pos_d;
    dir_t              dir_q, dir_d;
    logic [N_LEDS-1:0] leds_q, leds_d;
    logic              sweep_q, sweep_d;
    logic              pos_bad;
    logic              go_up;
    mode_t             mode;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .ENABLE (ENABLE),
        .CLEAR  (CLEAR),
        .TICK   (tick)
    );

    // Out-of-range codes only exist when N_LEDS is not a power of two.
    generate
        if (N_LEDS != (2 ** POS_W)) begin : g_sparse
            assign pos_bad = (pos_q > POS_MAX);
        end else begin : g_dense
            assign pos_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            leds_q  <= N_LEDS'(1);
            sweep_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            leds_q  <= leds_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        mode    = mode_t'(MODE);
        go_up   = 1'b0;
        pos_d   = pos_q;
        dir_d   = dir_q;
        leds_d  = leds_q;
        sweep_d = 1'b0;
        if (CLEAR) begin
            pos_d  = '0;
            dir_d  = DIR_UP;
            leds_d = N_LEDS'(1);
        end else if (tick) begin
            case (mode)
                MODE_WRAP_UP: begin
                    pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
                    dir_d = DIR_UP;
                end
                MODE_WRAP_DN: begin
                    pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
                    dir_d = DIR_DN;
                end
                default: begin
                    // Turn at an endpoint even if DIR was left pointing outward by a wrap mode.
                    go_up = (dir_q == DIR_UP) ? (pos_q != POS_MAX) : (pos_q == '0);
                    pos_d = go_up ? pos_q + POS_ONE : pos_q - POS_ONE;
                    dir_d = go_up ? DIR_UP : DIR_DN;
                    if (pos_d == POS_MAX) begin
                        dir_d = DIR_DN;
                    end else if (pos_d == '0) begin
                        dir_d = DIR_UP;
                    end
                end
            endcase
            if (pos_bad) begin
                pos_d = '0;
                if (mode == MODE_BOUNCE || mode == MODE_FILL) begin
                    dir_d = DIR_UP;
                end
            end
            case (mode)
                MODE_WRAP_UP: sweep_d = (pos_d == '0);
                MODE_WRAP_DN: sweep_d = (pos_d == POS_MAX);
                default:      sweep_d = (pos_d == '0) || (pos_d == POS_MAX);
            endcase
            if (mode == MODE_FILL) begin
                leds_d = N_LEDS'(fill_mask(32'(pos_d), N_LEDS));
            end else begin
`ifdef LED_SCANNER_TRAIL_EN
                leds_d = (N_LEDS'(1) << pos_d) | (N_LEDS'(1) << pos_q);
`else
                leds_d = N_LEDS'(1) << pos_d;
`endif
            end
        end
    end

    always_comb begin
        LEDS  = leds_q;
        POS   = pos_q;
        DIR   = dir_q;
        TICK  = tick;
        SWEEP = sweep_q;
    end

endmodule

// File: tb/tb_led_scanner.sv
// Directed-vector bench for led_scanner with N_LEDS=8, PRESCALE=4.
module tb_led_scanner;
    import led_scanner_pkg::*;

    localparam int N = 8;
    localparam int P = 4;
    localparam int CLK_NS = 10;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       enable = 1'b0;
    logic       clear  = 1'b0;
    logic [1:0] mode   = 2'b00;
    logic [7:0] leds;
    logic [2:0] pos;
    logic       dir, tick, sweep;

    int total = 0;
    int bad   = 0;

    led_scanner #(.N_LEDS(N), .PRESCALE(P)) dut (
        .CLK    (clk),
        .RSTn   (rst_n),
        .ENABLE (enable),
        .CLEAR  (clear),
        .MODE   (mode),
        .LEDS   (leds),
        .POS    (pos),
        .DIR    (dir),
        .TICK   (tick),
        .SWEEP  (sweep)
    );

    always #(CLK_NS/2) clk = ~clk;

    typedef struct {
        logic       clr;
        logic [1:0] mode;
        logic [2:0] pos;
        logic [7:0] leds;
        logic       dir;
        logic       sweep;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic [1:0] m, input logic [2:0] p,
                       input logic [7:0] l, input logic d, input logic s);
        vec_t v;
        v.clr = clr; v.mode = m; v.pos = p; v.leds = l; v.dir = d; v.sweep = s;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_leds(input logic [1:0] m, input logic [7:0] base, input logic [2:0] prev);
`ifdef LED_SCANNER_TRAIL_EN
        logic [7:0] one;
        one = 8'd1;
        if (m != 2'b11) return base | (one << prev);
`endif
        return base;
    endfunction

    task automatic wait_tick(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: no TICK within 20 cycles", name);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        longint     t, last_t;
        logic [2:0] prev_pos;
        logic [7:0] one8;
        int         cyc;

        one8 = 8'd1;
        // Bounce from reset
        for (int p = 1; p <= 7; p++) add(0, 2'b00, 3'(p), one8 << p, p == 7, p == 7);
        for (int p = 6; p >= 0; p--) add(0, 2'b00, 3'(p), one8 << p, p != 0, p == 0);
        add(0, 2'b00, 3'd1, 8'h02, 1'b0, 1'b0);
        // Wrap-down
        add(1, 2'b10, 3'd7, 8'h80, 1'b1, 1'b1);
        for (int p = 6; p >= 0; p--) add(0, 2'b10, 3'(p), one8 << p, 1'b1, 1'b0);
        add(0, 2'b10, 3'd7, 8'h80, 1'b1, 1'b1);
        // Fill
        add(1, 2'b11, 3'd1, 8'h03, 1'b0, 1'b0);
        add(0, 2'b11, 3'd2, 8'h07, 1'b0, 1'b0);
        add(0, 2'b11, 3'd3, 8'h0F, 1'b0, 1'b0);
        add(0, 2'b11, 3'd4, 8'h1F, 1'b0, 1'b0);
        add(0, 2'b11, 3'd5, 8'h3F, 1'b0, 1'b0);
        add(0, 2'b11, 3'd6, 8'h7F, 1'b0, 1'b0);
        add(0, 2'b11, 3'd7, 8'hFF, 1'b1, 1'b1);
        add(0, 2'b11, 3'd6, 8'h7F, 1'b1, 1'b0);
        add(0, 2'b11, 3'd5, 8'h3F, 1'b1, 1'b0);
        add(0, 2'b11, 3'd4, 8'h1F, 1'b1, 1'b0);
        add(0, 2'b11, 3'd3, 8'h0F, 1'b1, 1'b0);
        add(0, 2'b11, 3'd2, 8'h07, 1'b1, 1'b0);
        add(0, 2'b11, 3'd1, 8'h03, 1'b1, 1'b0);
        add(0, 2'b11, 3'd0, 8'h01, 1'b0, 1'b1);
        // Wrap-up, then mode changes mid-run
        add(1, 2'b01, 3'd1, 8'h02, 1'b0, 1'b0);
        for (int p = 2; p <= 7; p++) add(0, 2'b01, 3'(p), one8 << p, 1'b0, 1'b0);
        add(0, 2'b01, 3'd0, 8'h01, 1'b0, 1'b1);
        add(0, 2'b01, 3'd1, 8'h02, 1'b0, 1'b0);
        add(0, 2'b10, 3'd0, 8'h01, 1'b1, 1'b0);
        add(0, 2'b10, 3'd7, 8'h80, 1'b1, 1'b1);
        add(0, 2'b00, 3'd6, 8'h40, 1'b1, 1'b0);
        add(0, 2'b01, 3'd7, 8'h80, 1'b0, 1'b0);
        add(0, 2'b00, 3'd6, 8'h40, 1'b1, 1'b0);

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("reset_pos", 64'(pos), 64'd0);
        check("reset_dir", 64'(dir), 64'd0);
        check("reset_leds", 64'(leds), 64'h01);
        check("reset_tick", 64'(tick), 64'd0);
        check("reset_sweep", 64'(sweep), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        prev_pos = 3'd0;
        last_t   = -1;
        foreach (vecs[i]) begin
            if (vecs[i].clr) begin
                do_clear();
                prev_pos = 3'd0;
                last_t   = -1;
            end
            mode = vecs[i].mode;
            wait_tick($sformatf("vec%0d_tick", i), ok);
            if (!ok) continue;
            t = longint'($time);
            if (last_t >= 0) check($sformatf("vec%0d_period", i), 64'(t - last_t), 64'(P * CLK_NS));
            last_t = t;
            @(negedge clk);
            check($sformatf("vec%0d_pos", i), 64'(pos), 64'(vecs[i].pos));
            check($sformatf("vec%0d_dir", i), 64'(dir), 64'(vecs[i].dir));
            check($sformatf("vec%0d_leds", i), 64'(leds),
                  64'(exp_leds(vecs[i].mode, vecs[i].leds, prev_pos)));
            check($sformatf("vec%0d_sweep", i), 64'(sweep), 64'(vecs[i].sweep));
            prev_pos = vecs[i].pos;
        end

        // Freeze at POS=5 with two prescaler counts already spent
        mode = 2'b00;
        do_clear();
        for (int s = 0; s < 5; s++) begin
            wait_tick($sformatf("frz_step%0d", s), ok);
            @(negedge clk);
        end
        check("frz_pos5", 64'(pos), 64'd5);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("frz_tick_c%0d", c), 64'(tick), 64'd0);
            check($sformatf("frz_pos_c%0d", c), 64'(pos), 64'd5);
            check($sformatf("frz_leds_c%0d", c), 64'(leds), 64'(exp_leds(2'b00, 8'h20, 3'd4)));
        end
        enable = 1'b1;
        @(negedge clk);
        check("frz_resume_tick", 64'(tick), 64'd1);
        check("frz_resume_pos_hold", 64'(pos), 64'd5);
        @(negedge clk);
        check("frz_resume_pos", 64'(pos), 64'd6);
        check("frz_resume_leds", 64'(leds), 64'(exp_leds(2'b00, 8'h40, 3'd5)));

        // Reach POS=6 DIR=1, then CLEAR while disabled in fill mode
        wait_tick("clr_step7", ok);
        @(negedge clk);
        wait_tick("clr_step6", ok);
        @(negedge clk);
        check("clr_pre_pos", 64'(pos), 64'd6);
        check("clr_pre_dir", 64'(dir), 64'd1);
        enable = 1'b0;
        mode   = 2'b11;
        clear  = 1'b1;
        @(negedge clk);
        check("clr_pos", 64'(pos), 64'd0);
        check("clr_dir", 64'(dir), 64'd0);
        check("clr_leds", 64'(leds), 64'h01);
        check("clr_sweep", 64'(sweep), 64'd0);
        check("clr_tick", 64'(tick), 64'd0);
        clear  = 1'b0;
        enable = 1'b1;
        mode   = 2'b00;

        // Reset mid-count between edges
        wait_tick("rst_step", ok);
        @(negedge clk);
        check("rst_pre_pos", 64'(pos), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_pos", 64'(pos), 64'd0);
        check("rst_mid_leds", 64'(leds), 64'h01);
        check("rst_mid_dir", 64'(dir), 64'd0);
        check("rst_mid_tick", 64'(tick), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (tick === 1'b1) break;
        end
        check("rst_first_tick_cycles", 64'(cyc), 64'(P - 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
